// File: rtl/tdc_enc_pkg.sv
// tdc_enc_pkg
//   Shared encodings for the TDC raw-snapshot encoder: sample types,
//   operating modes, the default-geometry output record, a constant clog2
//   and the mode/type acceptance rule.
package tdc_enc_pkg;

    typedef enum logic [1:0] {
        TYPE_TOA  = 2'd0,
        TYPE_TOT  = 2'd1,
        TYPE_CAL  = 2'd2,
        TYPE_RSVD = 2'd3
    } tdc_type_e;

    typedef enum logic [1:0] {
        MODE_TOA     = 2'd0,
        MODE_TOA_TOT = 2'd1,
        MODE_CAL     = 2'd2,
        MODE_OFF     = 2'd3
    } tdc_mode_e;

    localparam int DEF_POS_W = 6;
    localparam int DEF_CNT_W = 3;

    // Output record for the default 63-tap / 3-bit-counter configuration.
    // The encoder declares the same layout locally so it follows its parameters.
    typedef struct packed {
        tdc_type_e              typ;
        logic [DEF_POS_W:0]     fine;
        logic [DEF_CNT_W-1:0]   coarse;
        logic                   err;
    } tdc_rec_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Reserved type is never accepted, whatever the mode.
    function automatic logic type_accepted(input logic [1:0] mode, input logic [1:0] typ);
        logic acc;
        case (mode)
            MODE_TOA:     acc = (typ == TYPE_TOA);
            MODE_TOA_TOT: acc = (typ == TYPE_TOA) || (typ == TYPE_TOT);
            MODE_CAL:     acc = (typ == TYPE_CAL);
            default:      acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/tdc_enc_fifo.sv
// tdc_enc_fifo
//   Synchronous FIFO, DEPTH a power of two (>= 2). A push while full is
//   ignored unless a pop happens in the same cycle; a pop while empty is
//   ignored. o_data shows the head straight from registered storage.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_push, i_data     write request and data
//   i_pop              read request (head advances)
//   o_data             head entry
//   o_full, o_empty    status
//   o_level            occupied entries, 0..DEPTH
module tdc_enc_fifo
    import tdc_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [clog2(DEPTH):0]    o_level
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/tdc_raw_encoder.sv
// tdc_raw_encoder
//   Encodes latched ring-oscillator snapshots (TOA, decimated TOT, CAL)
//   into {type, fine, coarse, err} records. Stage 1 filters by mode, stage 2
//   registers the encoded record, which is then pushed into an output FIFO
//   drained by valid/ready. Source is never backpressured: a record that
//   meets a full FIFO without a simultaneous pop is dropped and counted.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_mode                          0 TOA, 1 TOA+TOT, 2 CAL, 3 disabled
//   i_raw_valid/type/data           raw snapshot
//   i_raw_cnt_a, i_raw_cnt_b        ripple counters (posedge / negedge of mid tap)
//   o_out_valid, i_out_ready        output handshake
//   o_out_type/fine/coarse/err      FIFO head, zero while empty
//   o_fifo_level                    occupied entries
//   o_ovf_count                     saturating drop counter
module tdc_raw_encoder
    import tdc_enc_pkg::*;
#(
    parameter int NTAPS      = 63,
    parameter int CNT_W      = 3,
    parameter int POS_W      = clog2(NTAPS),
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   i_mode,
    input  logic                         i_raw_valid,
    input  logic [1:0]                   i_raw_type,
    input  logic [NTAPS-1:0]             i_raw_data,
    input  logic [CNT_W-1:0]             i_raw_cnt_a,
    input  logic [CNT_W-1:0]             i_raw_cnt_b,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [1:0]                   o_out_type,
    output logic [POS_W:0]               o_out_fine,
    output logic [CNT_W-1:0]             o_out_coarse,
    output logic                         o_out_err,
    output logic [clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [OVF_W-1:0]             o_ovf_count
);

    localparam int ND   = (NTAPS + 1) / 2;
    localparam int HALF = NTAPS / 2;

    typedef struct packed {
        logic [1:0]       typ;
        logic [POS_W:0]   fine;
        logic [CNT_W-1:0] coarse;
        logic             err;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // Returns {err, pos}. Full ring: an edge is a pair of equal neighbours,
    // including the wrap pair (NTAPS-1, 0).
    function automatic logic [POS_W:0] find_edge_ring(input logic [NTAPS-1:0] t);
        logic [POS_W-1:0] p;
        logic             seen;
        logic             multi;
        p     = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NTAPS; i++) begin
            if (t[i] == t[(i + 1) % NTAPS]) begin
                if (seen) multi = 1'b1;
                else begin
                    p    = POS_W'(i);
                    seen = 1'b1;
                end
            end
        end
        return {!seen || multi, p};
    endfunction

    // Decimated even taps alternate no longer, so the edge is a transition
    // between neighbouring samples; no wrap pair here.
    function automatic logic [POS_W:0] find_edge_tot(input logic [ND-1:0] d);
        logic [POS_W-1:0] p;
        logic             seen;
        logic             multi;
        p     = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int j = 0; j < ND - 1; j++) begin
            if (d[j] != d[j + 1]) begin
                if (seen) multi = 1'b1;
                else begin
                    p    = POS_W'(j);
                    seen = 1'b1;
                end
            end
        end
        return {!seen || multi, p};
    endfunction

    logic               r_s1_valid;
    logic [1:0]         r_s1_type;
    logic [NTAPS-1:0]   r_s1_data;
    logic [CNT_W-1:0]   r_s1_cnt_a;
    logic [CNT_W-1:0]   r_s1_cnt_b;
    logic               r_s2_valid;
    rec_t               r_s2_rec;
    logic [OVF_W-1:0]   r_ovf_count;

    logic [POS_W:0]     w_ring;
    logic [POS_W:0]     w_tot;
    logic               w_is_tot;
    logic [POS_W-1:0]   w_pos;
    logic [POS_W:0]     w_tap_idx;
    rec_t               w_rec;
    rec_t               w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_type  <= '0;
            r_s1_data  <= '0;
            r_s1_cnt_a <= '0;
            r_s1_cnt_b <= '0;
        end else begin
            r_s1_valid <= i_raw_valid && type_accepted(i_mode, i_raw_type);
            if (i_raw_valid) begin
                r_s1_type  <= i_raw_type;
                r_s1_data  <= i_raw_data;
                r_s1_cnt_a <= i_raw_cnt_a;
                r_s1_cnt_b <= i_raw_cnt_b;
            end
        end
    end

    // The TOT polarity bit d[pos] equals raw_data[pos] because d occupies the
    // low bits of the snapshot, so one index serves both sample kinds.
    always_comb begin
        w_ring    = find_edge_ring(r_s1_data);
        w_tot     = find_edge_tot(r_s1_data[ND-1:0]);
        w_is_tot  = (r_s1_type == TYPE_TOT);
        w_pos     = w_is_tot ? w_tot[POS_W-1:0] : w_ring[POS_W-1:0];
        w_tap_idx = w_is_tot ? {w_pos, 1'b0} : {1'b0, w_pos};
        w_rec        = '0;
        w_rec.typ    = r_s1_type;
        w_rec.fine   = {w_pos, r_s1_data[w_pos]};
        w_rec.coarse = (w_tap_idx <= (POS_W+1)'(HALF)) ? r_s1_cnt_a : r_s1_cnt_b;
        w_rec.err    = w_is_tot ? w_tot[POS_W] : w_ring[POS_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_rec   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_rec <= w_rec;
        end
    end

    assign o_out_valid = !w_empty;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_drop      = r_s2_valid && w_full && !w_pop;

    tdc_enc_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s2_valid),
        .i_data  (r_s2_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != {OVF_W{1'b1}})) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign o_ovf_count  = r_ovf_count;
    assign o_out_type   = o_out_valid ? w_head.typ    : '0;
    assign o_out_fine   = o_out_valid ? w_head.fine   : '0;
    assign o_out_coarse = o_out_valid ? w_head.coarse : '0;
    assign o_out_err    = o_out_valid ? w_head.err    : 1'b0;

endmodule

// File: tb/tb_tdc_raw_encoder.sv
module tb_tdc_raw_encoder;

    localparam int NTAPS = 63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode;
    logic        raw_valid;
    logic [1:0]  raw_type;
    logic [62:0] raw_data;
    logic [2:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_type;
    logic [6:0]  out_fine;
    logic [2:0]  out_coarse;
    logic        out_err;
    logic [2:0]  fifo_level;
    logic [7:0]  ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] typ;
        logic [6:0] fine;
        logic [2:0] coarse;
        logic       err;
    } exp_t;

    tdc_raw_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (mode),
        .i_raw_valid  (raw_valid),
        .i_raw_type   (raw_type),
        .i_raw_data   (raw_data),
        .i_raw_cnt_a  (cnt_a),
        .i_raw_cnt_b  (cnt_b),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_type   (out_type),
        .o_out_fine   (out_fine),
        .o_out_coarse (out_coarse),
        .o_out_err    (out_err),
        .o_fifo_level (fifo_level),
        .o_ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    // Reference: count equal neighbour pairs (ring) or transitions (decimated)
    // with a whole-vector XOR, take the lowest one, pick counter by tap index.
    function automatic exp_t model(input logic [1:0] typ, input logic [62:0] t,
                                   input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        logic [62:0] eqv;
        logic [30:0] tr;
        int n, pos, idx;
        pos = 0;
        if (typ == 2'd1) begin
            tr = t[30:0] ^ t[31:1];
            n  = $countones(tr);
            for (int i = 30; i >= 0; i--) if (tr[i]) pos = i;
            idx = 2 * pos;
        end else begin
            eqv = ~(t ^ {t[0], t[62:1]});
            n   = $countones(eqv);
            for (int i = 62; i >= 0; i--) if (eqv[i]) pos = i;
            idx = pos;
        end
        e.typ    = typ;
        e.fine   = 7'(2 * pos + (t[pos] ? 1 : 0));
        e.coarse = (idx <= NTAPS / 2) ? a : b;
        e.err    = (n != 1);
        return e;
    endfunction

    function automatic logic accepts(input logic [1:0] m, input logic [1:0] ty);
        return (m == 2'd0 && ty == 2'd0) || (m == 2'd1 && ty <= 2'd1) || (m == 2'd2 && ty == 2'd2);
    endfunction

    // Physically plausible ring snapshot: a single equal pair at p.
    function automatic logic [62:0] ring_pattern(input int p, input logic v);
        logic [62:0] t;
        for (int k = 0; k < 63; k++) t[(p + 1 + k) % 63] = v ^ ((k % 2) == 1);
        return t;
    endfunction

    task automatic drive_idle();
        raw_valid = 1'b0;
        raw_type  = 2'd0;
        raw_data  = '0;
        cnt_a     = 3'd0;
        cnt_b     = 3'd0;
    endtask

    task automatic send_one(input logic [1:0] ty, input logic [62:0] d,
                            input logic [2:0] a, input logic [2:0] b);
        raw_valid = 1'b1;
        raw_type  = ty;
        raw_data  = d;
        cnt_a     = a;
        cnt_b     = b;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd0;
        out_ready = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        n_checks++;
        if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d expected 0", ovf_count); end
        n_checks++;
        if ({out_type, out_fine, out_coarse, out_err} !== 13'd0)
            begin n_fail++; $display("FAIL reset_outs: got %0h expected 0", {out_type, out_fine, out_coarse, out_err}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_toa_latency();
        logic [62:0] p1, p2;
        for (int i = 0; i < 63; i++) p1[i] = (i <= 10) ? (i % 2 == 0) : (i % 2 == 1);
        for (int i = 0; i < 63; i++) p2[i] = (i % 2 == 0);
        mode = 2'd0;
        out_ready = 1'b0;
        send_one(2'd0, p1, 3'd5, 3'd2);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL toa_lat_e0: got %b expected 0", out_valid); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL toa_lat_e1: got %b expected 0", out_valid); end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_type, out_fine, out_coarse, out_err} !== {1'b1, 2'd0, 7'd21, 3'd5, 1'b0})
            begin n_fail++; $display("FAIL toa_basic: got v%b t%0d f%0d c%0d e%b expected v1 t0 f21 c5 e0",
                                     out_valid, out_type, out_fine, out_coarse, out_err); end
        pop_one();
        send_one(2'd0, p2, 3'd1, 3'd6);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_type, out_fine, out_coarse, out_err} !== {1'b1, 2'd0, 7'd125, 3'd6, 1'b0})
            begin n_fail++; $display("FAIL toa_wrap: got v%b t%0d f%0d c%0d e%b expected v1 t0 f125 c6 e0",
                                     out_valid, out_type, out_fine, out_coarse, out_err); end
        pop_one();
        n_checks++;
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL toa_drained: got %0d expected 0", fifo_level); end
    endtask

    // Directed bubble / no-edge / TOT cases: {mode, type, data, cntA, cntB, expected}.
    task automatic test_edge_cases();
        logic [62:0] d [6];
        logic [1:0]  m [6];
        logic [1:0]  ty [6];
        exp_t        ex [6];
        for (int i = 0; i < 63; i++)
            d[0][i] = (i <= 10) ? (i % 2 == 0) : (i <= 20) ? (i % 2 == 1) : (i % 2 == 0);
        m[0] = 2'd0; ty[0] = 2'd0; ex[0] = '{2'd0, 7'd21, 3'd4, 1'b1};
        d[1] = '1;
        m[1] = 2'd0; ty[1] = 2'd0; ex[1] = '{2'd0, 7'd1, 3'd4, 1'b1};
        d[2] = {31'h5a5a_1234, 32'h0000_001f};
        m[2] = 2'd1; ty[2] = 2'd1; ex[2] = '{2'd1, 7'd9, 3'd4, 1'b0};
        d[3] = {31'h7fff_ffff, 32'hffe0_0000};
        m[3] = 2'd1; ty[3] = 2'd1; ex[3] = '{2'd1, 7'd40, 3'd3, 1'b0};
        d[4] = {31'h1357_2468, 32'h0000_0000};
        m[4] = 2'd1; ty[4] = 2'd1; ex[4] = '{2'd1, 7'd0, 3'd4, 1'b1};
        for (int i = 0; i < 63; i++) d[5][i] = (i % 3 == 0);
        m[5] = 2'd2; ty[5] = 2'd2; ex[5] = model(2'd2, d[5], 3'd4, 3'd3);
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mode = m[k];
            send_one(ty[k], d[k], 3'd4, 3'd3);
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_type, out_fine, out_coarse, out_err} !== {1'b1, ex[k]})
                begin n_fail++; $display("FAIL edge_case_%0d: got v%b t%0d f%0d c%0d e%b expected v1 t%0d f%0d c%0d e%b",
                                         k, out_valid, out_type, out_fine, out_coarse, out_err,
                                         ex[k].typ, ex[k].fine, ex[k].coarse, ex[k].err); end
            pop_one();
        end
    endtask

    task automatic test_mode_filter();
        logic [62:0] p;
        p = ring_pattern(7, 1'b0);
        out_ready = 1'b0;
        mode = 2'd2;
        for (int k = 0; k < 3; k++) begin
            raw_valid = 1'b1; raw_type = 2'(k); raw_data = p; cnt_a = 3'(k); cnt_b = 3'd7;
            @(negedge clk);
        end
        drive_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL mode2_level: got %0d expected 1", fifo_level); end
        n_checks++;
        if (out_type !== 2'd2 || out_coarse !== 3'd2)
            begin n_fail++; $display("FAIL mode2_type: got t%0d c%0d expected t2 c2", out_type, out_coarse); end
        pop_one();
        mode = 2'd3;
        for (int k = 0; k < 4; k++) begin
            raw_valid = 1'b1; raw_type = 2'(k); raw_data = p; cnt_a = 3'd1; cnt_b = 3'd1;
            @(negedge clk);
        end
        drive_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0)
            begin n_fail++; $display("FAIL mode3_empty: got v%b l%0d expected v0 l0", out_valid, fifo_level); end
        // Mode is captured with the sample; a later change must not drop it.
        mode = 2'd0;
        send_one(2'd0, p, 3'd3, 3'd3);
        mode = 2'd3;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_type !== 2'd0)
            begin n_fail++; $display("FAIL mode_inflight: got v%b t%0d expected v1 t0", out_valid, out_type); end
        pop_one();
        n_checks++;
        if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL mode_ovf: got %0d expected 0", ovf_count); end
    endtask

    task automatic test_overflow();
        logic [62:0] p;
        p = ring_pattern(5, 1'b1);
        mode = 2'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            raw_valid = 1'b1; raw_type = 2'd0; raw_data = p; cnt_a = 3'(k); cnt_b = 3'd7;
            @(negedge clk);
        end
        drive_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
        n_checks++;
        if (ovf_count !== 8'd2) begin n_fail++; $display("FAIL ovf_count: got %0d expected 2", ovf_count); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_coarse !== 3'(k))
                begin n_fail++; $display("FAIL ovf_order_%0d: got v%b c%0d expected v1 c%0d", k, out_valid, out_coarse, k); end
            pop_one();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [62:0] p;
        p = ring_pattern(3, 1'b0);
        mode = 2'd1;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            raw_valid = 1'b1; raw_type = 2'd0; raw_data = p; cnt_a = 3'(k); cnt_b = 3'd0;
            @(negedge clk);
        end
        drive_idle();
        repeat (3) @(negedge clk);
        n_checks++;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got %0d expected 4", fifo_level); end
        send_one(2'd0, p, 3'd5, 3'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (fifo_level !== 3'd4 || ovf_count !== 8'd2)
            begin n_fail++; $display("FAIL b2b_pushpop: got l%0d o%0d expected l4 o2", fifo_level, ovf_count); end
        for (int k = 2; k <= 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_coarse !== 3'(k))
                begin n_fail++; $display("FAIL b2b_order_%0d: got v%b c%0d expected v1 c%0d", k, out_valid, out_coarse, k); end
            pop_one();
        end
    endtask

    task automatic test_reset_midflight();
        logic [62:0] p;
        p = ring_pattern(30, 1'b1);
        mode = 2'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            raw_valid = 1'b1; raw_type = 2'd0; raw_data = p; cnt_a = 3'(k); cnt_b = 3'd0;
            @(negedge clk);
        end
        drive_idle();
        n_checks++;
        if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL rst_pre_level: got %0d expected 3", fifo_level); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || ovf_count !== 8'd0)
            begin n_fail++; $display("FAIL rst_async: got v%b l%0d o%0d expected v0 l0 o0", out_valid, fifo_level, ovf_count); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_%0d: got %b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_random();
        exp_t q [$];
        exp_t s1, s2;
        logic s1v, s2v, pop;
        int   m_ovf, sz;
        logic [62:0] d;
        s1v = 1'b0; s2v = 1'b0; s1 = '0; s2 = '0; m_ovf = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = (cyc < 300) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
            sz = q.size();
            n_checks++;
            if (out_valid !== (sz != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, out_valid, sz != 0); end
            n_checks++;
            if (fifo_level !== 3'(sz)) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", cyc, fifo_level, sz); end
            n_checks++;
            if (ovf_count !== 8'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %0d expected %0d", cyc, ovf_count, m_ovf); end
            pop = (sz != 0) && out_ready;
            if (pop) begin
                n_checks++;
                if ({out_type, out_fine, out_coarse, out_err} !== q[0])
                    begin n_fail++; $display("FAIL rnd_data@%0d: got %0h expected %0h", cyc,
                                             {out_type, out_fine, out_coarse, out_err}, q[0]); end
                void'(q.pop_front());
            end
            if (s2v) begin
                if (sz == 4 && !pop) begin
                    if (m_ovf < 255) m_ovf++;
                end else q.push_back(s2);
            end
            s2v = s1v;
            s2  = s1;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            raw_valid = ($urandom_range(0, 3) != 0);
            raw_type  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: d = ring_pattern($urandom_range(0, 62), 1'($urandom_range(0, 1)));
                1: begin
                    d = {$urandom, $urandom};
                    for (int i = 0; i < 32; i++) d[i] = (i <= $urandom_range(0, 31)) ? 1'b1 : 1'b0;
                end
                default: d = {$urandom, $urandom};
            endcase
            raw_data = d;
            cnt_a    = 3'($urandom_range(0, 7));
            cnt_b    = 3'($urandom_range(0, 7));
            s1v = raw_valid && accepts(mode, raw_type);
            s1  = model(raw_type, raw_data, cnt_a, cnt_b);
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_toa_latency();
        test_edge_cases();
        test_mode_filter();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_raw_encoder.md
Name: tdc_raw_encoder

Overview:
Parametrised successor to the single-line ideal TDC delay-line capture. It accepts already-latched raw snapshots from an odd-length NAND ring oscillator: TOA, TOT (even-tap decimated) and calibration samples, each with the ripple counters A and B. It locates the propagating edge, encodes fine and coarse codes, flags bubble errors and filters by operating mode. Results are buffered in a small FIFO drained by a valid/ready handshake toward the readout.

Parameters:
NTAPS, 63, ring length in stages; must be odd and at least 7
CNT_W, 3, ripple counter width
POS_W, 6, clog2(NTAPS); edge-position width
FIFO_DEPTH, 4, output FIFO entries; power of two
OVF_W, 8, overflow counter width

Ports:
clk  in  1  block clock, rising edge
Reset  in  1  asynchronous, active-low reset
mode  in  2  0 = TOA only, 1 = TOA+TOT, 2 = CAL only, 3 = disabled
raw_valid  in  1  raw sample present this cycle
raw_type  in  2  0 = TOA, 1 = TOT, 2 = CAL, 3 = reserved (always dropped)
raw_data  in  NTAPS  tap snapshot; for TOT, low (NTAPS+1)/2 bits hold tap[0], tap[2], …, tap[NTAPS-1]
raw_cntA  in  CNT_W  ripple counter A (posedge of tap[NTAPS/2])
raw_cntB  in  CNT_W  ripple counter B (negedge of tap[NTAPS/2])
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_type  out  2  sample type
out_fine  out  POS_W+1  {edge position, polarity bit}
out_coarse  out  CNT_W  selected counter
out_err  out  1  bubble or no-edge error
fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries
ovf_count  out  OVF_W  dropped-on-full count, saturating

Behaviour:
- Reset low (asynchronous): all pipeline valids, FIFO pointers, fifo_level and ovf_count clear to 0. All out_* are 0. Release is synchronous to clk.
- Acceptance at stage 1 register:
  - mode 0 accepts TOA. Mode 1 accepts TOA and TOT. Mode 2 accepts CAL. Mode 3 accepts nothing.
  - Rejected samples are discarded silently and are not counted.
  - Mode is sampled in the cycle raw_valid is seen. In-flight samples complete regardless of later mode changes.
- Stage 2 encode, TOA/CAL:
  - Pair i compares tap[i] and tap[i+1] for i = 0..NTAPS-2. Pair NTAPS-1 compares tap[NTAPS-1] and tap[0] (wrap).
  - The edge is a pair with equal bits. pos = lowest such i.
  - err = 1 if the number of equal pairs is not exactly 1. If there are none, pos = 0.
- Stage 2 encode, TOT:
  - d = decimated vector of (NTAPS+1)/2 bits.
  - pos = lowest j with d[j] != d[j+1], for j ≤ (NTAPS-3)/2.
  - err = 1 if none (pos = 0) or if more than one.
- Fine and coarse codes:
  - out_fine = {pos, s[pos]}, where s is raw_data for TOA/CAL and d for TOT.
  - Coarse selection uses the tap index of the edge: pos for TOA/CAL, 2·pos for TOT.
  - If that index ≤ NTAPS/2 (integer division), coarse = cntA; otherwise coarse = cntB. No arithmetic on counters.
- Latency: sample at raw_valid cycle N is written to the FIFO at edge N+2. out_valid rises at N+2 if the FIFO was empty.
- No backpressure to the source: raw input is always taken.
  - If the FIFO is full at a write and no pop occurs the same cycle, the entry is dropped and ovf_count increments. ovf_count saturates at 2^OVF_W-1 and is cleared only by Reset.
  - Simultaneous push and pop at full: both occur; no drop.
- Handshake: pop when out_valid && out_ready. out_* show the FIFO head combinationally from registered storage and are stable while out_valid && !out_ready. Pop when empty has no effect.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact: 0..FIFO_DEPTH.
- Reset asserted mid-operation discards pipeline and FIFO contents.

Decomposition:
- Package tdc_enc_pkg:
  - type encodings TYPE_TOA = 0, TYPE_TOT = 1, TYPE_CAL = 2
  - mode encodings
  - packed record {type, fine, coarse, err}
  - function clog2
- One natural sub-module: tdc_enc_fifo, a parametrised synchronous FIFO with push/pop, full/empty and level, same clk and Reset.
- The edge finder stays inline as a combinational function within the encoder.

Test Plan:
- TOA, mode 0, NTAPS = 63:
  - Stimulus: taps 0..10 alternate starting at 1, tap[11] = 1, alternate thereafter; cntA = 5, cntB = 2.
  - Response: after 2 cycles, type 0, fine = 21 ({10, 1}), coarse = 5, err = 0.
- Wrap edge:
  - Stimulus: tap[i] = ~i[0] for all i (tap[62] = tap[0] = 1); cntA = 1, cntB = 6.
  - Response: fine = 125 ({62, 1}), coarse = 6, err = 0.
- Bubble:
  - Stimulus: equal pairs at i = 10 and i = 20.
  - Response: pos = 10, err = 1. No-edge pattern (impossible all-differ) gives pos = 0, err = 1.
- Mode filter:
  - Stimulus: mode 2, send TOA, TOT and CAL back-to-back.
  - Response: only CAL is output. Mode 3 produces no outputs. ovf_count stays 0.
- Overflow:
  - Stimulus: out_ready = 0, six accepted samples.
  - Response: fifo_level = 4, ovf_count = 2, the first four are retained in order. A pop plus push in the same cycle at full causes no increment.
- Reset:
  - Stimulus: assert Reset with 3 entries queued and 2 in flight.
  - Response: out_valid = 0, fifo_level = 0 immediately. Nothing is emitted after release.
